// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer.
//   - opcode numbering used by the control unit and the ALU
//   - {Z,N,C,V} flag bit positions
//   - done-select encoding from the opcode classifier
//   - sequencer state encoding
package alu_pkg;

  localparam int unsigned OP_AND  = 0;
  localparam int unsigned OP_DEC  = 1;
  localparam int unsigned OP_DIV  = 2;
  localparam int unsigned OP_INC  = 3;
  localparam int unsigned OP_LSH  = 4;
  localparam int unsigned OP_MOD  = 5;
  localparam int unsigned OP_MOV  = 6;
  localparam int unsigned OP_MUL  = 7;
  localparam int unsigned OP_NOT  = 8;
  localparam int unsigned OP_OR   = 9;
  localparam int unsigned OP_ADD  = 10;
  localparam int unsigned OP_RSH  = 11;
  localparam int unsigned OP_ROL  = 12;
  localparam int unsigned OP_ROR  = 13;
  localparam int unsigned OP_SUB  = 14;
  localparam int unsigned OP_TST  = 15;
  localparam int unsigned OP_XOR  = 16;
  localparam int unsigned OP_CMP  = 17;
  localparam int unsigned OP_LAST = 17;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Which ALU done line a multi-cycle op completes on.
  localparam logic [1:0] DONE_DIV  = 2'd0;
  localparam logic [1:0] DONE_MOD  = 2'd1;
  localparam logic [1:0] DONE_MUL  = 2'd2;
  localparam logic [1:0] DONE_NONE = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StStart,
    StWait,
    StResp
  } seq_state_e;

endpackage

// File: rtl/alu_op_class.sv
// Combinational opcode classifier.
//   op           : opcode from the control unit
//   is_legal     : opcode is in 0..OP_LAST
//   is_multicycle: opcode is DIV, MOD or MUL (needs start/done handshake)
//   done_select  : which ALU done line completes the op (DONE_NONE otherwise)
module alu_op_class
  import alu_pkg::*;
#(
  parameter int unsigned OP_W = 5
) (
  input  logic [OP_W-1:0] op,
  output logic            is_legal,
  output logic            is_multicycle,
  output logic [1:0]      done_select
);

  logic [31:0] op_ext;

  always_comb begin
    op_ext        = 32'(op);
    is_legal      = (op_ext <= OP_LAST);
    is_multicycle = 1'b0;
    done_select   = DONE_NONE;
    case (op_ext)
      OP_DIV: begin
        is_multicycle = 1'b1;
        done_select   = DONE_DIV;
      end
      OP_MOD: begin
        is_multicycle = 1'b1;
        done_select   = DONE_MOD;
      end
      OP_MUL: begin
        is_multicycle = 1'b1;
        done_select   = DONE_MUL;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Issue controller between the control unit and the 16-bit ALU.
// Accepts one op at a time on the req_* valid/ready port, registers operands onto
// alu_op/alu_a/alu_b (held until the next accept), pulses alu_start for DIV/MOD/MUL
// and waits for the matching done, then presents the captured result/flags on the
// rsp_* valid/ready port. Illegal opcodes and watchdog expiry are reported there too.
//   clk, rst              : clock, asynchronous active-low reset
//   req_valid/ready/op/a/b: request port (ready only in IDLE)
//   alu_op/a/b/start      : registered ALU inputs and one-cycle start pulse
//   alu_result/_high/flags: ALU outputs; alu_done_div/mod/mul completion strobes
//   rsp_valid/ready       : response handshake
//   rsp_result/_high/flags: captured ALU outputs (high word only for MUL)
//   rsp_illegal/timeout   : rejected opcode / multi-cycle op aborted
//   busy                  : sequencer not in IDLE
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned OP_W           = 5,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_start,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] alu_result_high,
  input  logic              alu_done_div,
  input  logic              alu_done_mod,
  input  logic              alu_done_mul,
  input  logic [3:0]        alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [DATA_W-1:0] rsp_result_high,
  output logic [3:0]        rsp_flags,
  output logic              rsp_illegal,
  output logic              rsp_timeout,
  output logic              busy
);

  localparam int unsigned WdW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT_CYCLES - 1);

  seq_state_e state_q, state_d;

  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              alu_start_q, alu_start_d;
  logic [1:0]        sel_q, sel_d;
  logic [WdW-1:0]    wd_q, wd_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic [DATA_W-1:0] rsp_high_q, rsp_high_d;
  logic [3:0]        rsp_flags_q, rsp_flags_d;
  logic              rsp_illegal_q, rsp_illegal_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic       req_legal;
  logic       req_multi;
  logic [1:0] req_sel;
  logic       done_hit;

  alu_op_class #(
    .OP_W (OP_W)
  ) u_op_class (
    .op            (req_op),
    .is_legal      (req_legal),
    .is_multicycle (req_multi),
    .done_select   (req_sel)
  );

  // Only the done line belonging to the op in flight counts.
  always_comb begin
    done_hit = 1'b0;
    unique case (sel_q)
      DONE_DIV: done_hit = alu_done_div;
      DONE_MOD: done_hit = alu_done_mod;
      DONE_MUL: done_hit = alu_done_mul;
      default:  done_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    alu_op_d      = alu_op_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_start_d   = 1'b0;
    sel_d         = sel_q;
    wd_d          = wd_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_high_d    = rsp_high_q;
    rsp_flags_d   = rsp_flags_q;
    rsp_illegal_d = rsp_illegal_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (!req_legal) begin
            // ALU inputs keep the previous op's operands.
            state_d       = StResp;
            rsp_valid_d   = 1'b1;
            rsp_illegal_d = 1'b1;
            rsp_result_d  = '0;
            rsp_high_d    = '0;
            rsp_flags_d   = '0;
          end else begin
            alu_op_d = req_op;
            alu_a_d  = req_a;
            alu_b_d  = req_b;
            sel_d    = req_sel;
            if (req_multi) begin
              state_d     = StStart;
              alu_start_d = 1'b1;
            end else begin
              state_d = StExec;
            end
          end
        end
      end

      StExec: begin
        state_d      = StResp;
        rsp_valid_d  = 1'b1;
        rsp_result_d = alu_result;
        rsp_high_d   = '0;
        rsp_flags_d  = alu_flags;
      end

      // Done lines are not looked at here: they may still carry the previous op's done.
      StStart: begin
        state_d = StWait;
        wd_d    = '0;
      end

      StWait: begin
        if (done_hit) begin
          state_d      = StResp;
          rsp_valid_d  = 1'b1;
          rsp_result_d = alu_result;
          rsp_high_d   = (sel_q == DONE_MUL) ? alu_result_high : '0;
          rsp_flags_d  = alu_flags;
        end else if (wd_q == WdMax) begin
          state_d       = StResp;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_result_d  = '0;
          rsp_high_d    = '0;
          rsp_flags_d   = '0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      StResp: begin
        if (rsp_ready) begin
          state_d       = StIdle;
          rsp_valid_d   = 1'b0;
          rsp_illegal_d = 1'b0;
          rsp_timeout_d = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      alu_op_q      <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_start_q   <= 1'b0;
      sel_q         <= DONE_NONE;
      wd_q          <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_high_q    <= '0;
      rsp_flags_q   <= '0;
      rsp_illegal_q <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      alu_op_q      <= alu_op_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_start_q   <= alu_start_d;
      sel_q         <= sel_d;
      wd_q          <= wd_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_high_q    <= rsp_high_d;
      rsp_flags_q   <= rsp_flags_d;
      rsp_illegal_q <= rsp_illegal_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign req_ready       = (state_q == StIdle);
  assign busy            = (state_q != StIdle);
  assign alu_op          = alu_op_q;
  assign alu_a           = alu_a_q;
  assign alu_b           = alu_b_q;
  assign alu_start       = alu_start_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_result      = rsp_result_q;
  assign rsp_result_high = rsp_high_q;
  assign rsp_flags       = rsp_flags_q;
  assign rsp_illegal     = rsp_illegal_q;
  assign rsp_timeout     = rsp_timeout_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer. The bench plays the ALU: it drives
// hand-computed results/flags and done strobes at chosen cycles.
module tb_alu_sequencer;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned TO     = 64;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic              alu_start;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] alu_result_high;
  logic              alu_done_div;
  logic              alu_done_mod;
  logic              alu_done_mul;
  logic [3:0]        alu_flags;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic [DATA_W-1:0] rsp_result_high;
  logic [3:0]        rsp_flags;
  logic              rsp_illegal;
  logic              rsp_timeout;
  logic              busy;

  int n_checks = 0;
  int n_pass   = 0;
  int start_cnt = 0;
  int n;

  alu_sequencer #(
    .DATA_W         (DATA_W),
    .OP_W           (OP_W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_a           (req_a),
    .req_b           (req_b),
    .alu_op          (alu_op),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_start       (alu_start),
    .alu_result      (alu_result),
    .alu_result_high (alu_result_high),
    .alu_done_div    (alu_done_div),
    .alu_done_mod    (alu_done_mod),
    .alu_done_mul    (alu_done_mul),
    .alu_flags       (alu_flags),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_result      (rsp_result),
    .rsp_result_high (rsp_result_high),
    .rsp_flags       (rsp_flags),
    .rsp_illegal     (rsp_illegal),
    .rsp_timeout     (rsp_timeout),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count start pulses on the falling edge, away from the active edge.
  always @(negedge clk) if (alu_start) start_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; returns #1 after the accept edge.
  task automatic issue(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    alu_result = '0; alu_result_high = '0; alu_flags = '0;
    alu_done_div = 1'b0; alu_done_mod = 1'b0; alu_done_mul = 1'b0;
    rsp_ready = 1'b1;
    #12;
    check("reset_outputs", {alu_op, alu_a, alu_b, alu_start, rsp_valid, rsp_illegal,
          rsp_timeout, busy}, 32'd0);
    check("reset_rsp_data", {rsp_result, rsp_result_high}, 32'd0);
    check("reset_req_ready", req_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // ADD 10+5: response one edge after EXEC.
    alu_result = 16'd15; alu_flags = 4'b0000; alu_result_high = 16'h5555;
    start_cnt = 0;
    issue(5'd10, 16'd10, 16'd5);
    check("add_operands", {alu_op, alu_a, alu_b}, {5'd10, 16'd10, 16'd5} & 32'hFFFF_FFFF);
    check("add_exec_no_valid", {rsp_valid, busy, req_ready}, 3'b010);
    tick();
    check("add_rsp_valid", rsp_valid, 1);
    check("add_rsp_result", rsp_result, 16'd15);
    check("add_rsp_high", rsp_result_high, 0);
    check("add_rsp_flags", rsp_flags, 4'b0000);
    alu_result = 16'h1234;
    tick();
    check("add_handshake", {rsp_valid, req_ready, busy}, 3'b010);
    check("add_result_retained", rsp_result, 16'd15);
    check("add_no_start", start_cnt, 0);

    // DIV -20/5 = -4; stale done_div in START and done_mod in WAIT are ignored.
    alu_result = 16'hFFFC; alu_flags = 4'b0100; alu_result_high = 16'hAAAA;
    start_cnt = 0;
    issue(5'd2, 16'hFFEC, 16'd5);
    check("div_start_high", {alu_start, busy}, 2'b11);
    alu_done_div = 1'b1;
    tick();
    check("div_start_drop", {alu_start, rsp_valid}, 2'b00);
    alu_done_div = 1'b0; alu_done_mod = 1'b1;
    tick();
    check("div_ignore_mod", rsp_valid, 0);
    alu_done_mod = 1'b0; alu_done_div = 1'b1;
    tick();
    alu_done_div = 1'b0;
    check("div_rsp_valid", rsp_valid, 1);
    check("div_rsp_result", rsp_result, 16'hFFFC);
    check("div_rsp_high_zero", rsp_result_high, 0);
    check("div_rsp_flag_n", rsp_flags, 4'b0100);
    check("div_operands_held", {alu_a, alu_b}, {16'hFFEC, 16'd5});
    tick();
    check("div_one_start", start_cnt, 1);

    // MUL -11*5 = -55 -> high FFFF, low FFC9.
    alu_result = 16'hFFC9; alu_result_high = 16'hFFFF; alu_flags = 4'b0100;
    issue(5'd7, 16'hFFF5, 16'd5);
    tick();
    alu_done_mul = 1'b1;
    tick();
    alu_done_mul = 1'b0;
    check("mul_rsp", {rsp_valid, rsp_result}, {1'b1, 16'hFFC9});
    check("mul_rsp_high", rsp_result_high, 16'hFFFF);
    check("mul_rsp_flags", rsp_flags, 4'b0100);
    tick();

    // Modulo op with no done: timeout after exactly TO WAIT edges.
    alu_result = 16'h0777; alu_flags = 4'b1111;
    issue(5'd5, 16'd9, 16'd4);
    tick();
    n = 0;
    for (int i = 0; i < 4 * TO; i++) begin
      tick();
      n++;
      if (rsp_valid) break;
    end
    check("mod_timeout_edges", n, TO);
    check("mod_timeout_bits", {rsp_valid, rsp_timeout, rsp_illegal}, 3'b110);
    check("mod_timeout_data", {rsp_result, rsp_result_high}, 32'd0);
    check("mod_timeout_flags", rsp_flags, 0);
    tick();
    check("mod_timeout_clear", {rsp_valid, rsp_timeout, req_ready}, 3'b001);

    // INC after timeout is accepted normally.
    alu_result = 16'd8; alu_flags = 4'b0000;
    issue(5'd3, 16'd7, 16'd0);
    tick();
    check("inc_after_timeout", {rsp_valid, rsp_timeout, rsp_result}, {2'b10, 16'd8});
    tick();

    // Done and timeout on the same edge: done wins.
    alu_result = 16'd3; alu_flags = 4'b0000;
    issue(5'd5, 16'd11, 16'd4);
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    check("race_not_yet", rsp_valid, 0);
    alu_done_mod = 1'b1;
    tick();
    alu_done_mod = 1'b0;
    check("race_done_wins", {rsp_valid, rsp_timeout, rsp_result}, {2'b10, 16'd3});
    tick();

    // Illegal op 20 under backpressure; a legal request stays pending meanwhile.
    rsp_ready = 1'b0;
    start_cnt = 0;
    issue(5'd20, 16'hDEAD, 16'hBEEF);
    check("ill_rsp", {rsp_valid, rsp_illegal, alu_start}, 3'b110);
    check("ill_alu_unchanged", {alu_op, alu_a}, {5'd5, 16'd11});
    check("ill_zero_data", {rsp_result, rsp_flags}, 20'd0);
    req_valid = 1'b1; req_op = 5'd10; req_a = 16'd1; req_b = 16'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ill_hold", {rsp_valid, rsp_illegal, req_ready, busy, alu_op},
            {4'b1101, 5'd5});
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("ill_release", {rsp_valid, rsp_illegal, req_ready}, 3'b001);
    check("ill_no_start", start_cnt, 0);

    // Async reset in the middle of a MUL wait.
    alu_result = 16'd12; alu_result_high = 16'd0;
    issue(5'd7, 16'd3, 16'd4);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_async_zero", {alu_op, alu_a, alu_b, alu_start, rsp_valid, busy}, 32'd0);
    check("rst_rsp_zero", {rsp_result, rsp_illegal, rsp_timeout}, 18'd0);
    alu_done_mul = 1'b1;
    tick();
    alu_done_mul = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_no_response", {rsp_valid, req_ready}, 2'b01);
    alu_result = 16'd2; alu_flags = 4'b0000;
    issue(5'd10, 16'd1, 16'd1);
    tick();
    check("post_rst_add", {rsp_valid, rsp_result}, {1'b1, 16'd2});
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
